// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serializer_pkg
// Brief    : Frame layout constants, FSM state type and frame builder for the
//            serial link transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package serializer_pkg;

    localparam int         FRAME_BITS = 18;
    localparam int         DATA_LSB   = 5;
    // Receive-window order: bit 0 is transmitted first.
    localparam logic [4:0] PREAMBLE   = 5'b10001;
    localparam logic [4:0] POSTAMBLE  = 5'b01110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d);
        logic [FRAME_BITS-1:0] f;
        f                                = '0;
        f[DATA_LSB-1:0]                  = PREAMBLE;
        f[DATA_LSB+7:DATA_LSB]           = d;
        f[FRAME_BITS-1:DATA_LSB+8]       = POSTAMBLE;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serializer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : serializer_fifo
// Brief    : Synchronous show-ahead byte FIFO; head is valid whenever !empty.
// Revision : 1.0 - initial release
// ============================================================================
module serializer_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int            c_AW  = $clog2(DEPTH);
    localparam logic [c_AW:0] c_ONE = 1;

    logic [7:0]    r_mem [DEPTH];
    logic [c_AW:0] r_wptr;
    logic [c_AW:0] r_rptr;
    logic          w_wr;
    logic          w_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign empty = (r_wptr == r_rptr);
    assign w_wr  = push && !full;
    assign w_rd  = pop && !empty;
    assign head  = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + c_ONE;
            if (w_rd) r_rptr <= r_rptr + c_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wptr[c_AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
// Module   : serializer
// Brief    : Byte-to-serial framer: FIFO-buffered bytes sent as 18-bit frames
//            separated by GAP_BITS idle zeros.
// Revision : 1.0 - initial release
// ============================================================================
module serializer
    import serializer_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int GAP_BITS = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       serout,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [4:0] c_LAST_BIT = 5'(FRAME_BITS - 1);
    localparam logic [7:0] c_LAST_GAP = 8'(GAP_BITS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_shift_nxt;
    logic [FRAME_BITS-1:0] w_frame;
    logic [4:0]            r_bitcnt;
    logic [4:0]            w_bitcnt_nxt;
    logic [7:0]            r_gapcnt;
    logic [7:0]            w_gapcnt_nxt;
    logic                  r_serout;
    logic                  w_serout_nxt;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_gap_done;
    logic [7:0]            w_head;

    serializer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    assign in_ready   = !w_full;
    assign w_push     = in_valid && !w_full;
    assign w_gap_done = (r_state == GAP) && (r_gapcnt == c_LAST_GAP);
    assign w_pop      = ((r_state == IDLE) || w_gap_done) && !w_empty;
    assign w_frame    = build_frame(w_head);

    assign serout     = r_serout;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == SEND) && (r_bitcnt == c_LAST_BIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_gapcnt <= '0;
            r_serout <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_gapcnt <= w_gapcnt_nxt;
            r_serout <= w_serout_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_gapcnt_nxt = r_gapcnt;
        w_serout_nxt = 1'b0;

        case (r_state)
            IDLE: ;
            SEND: begin
                if (r_bitcnt == c_LAST_BIT) begin
                    w_state_nxt  = GAP;
                    w_bitcnt_nxt = '0;
                    w_gapcnt_nxt = '0;
                end else begin
                    w_serout_nxt = r_shift[0];
                    w_shift_nxt  = r_shift >> 1;
                    w_bitcnt_nxt = r_bitcnt + 5'd1;
                end
            end
            GAP: begin
                if (w_gap_done) begin
                    w_state_nxt  = IDLE;
                    w_bitcnt_nxt = '0;
                    w_gapcnt_nxt = '0;
                end else begin
                    w_gapcnt_nxt = r_gapcnt + 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // A pop only happens from IDLE or at the end of a gap; it starts a frame.
        if (w_pop) begin
            w_state_nxt  = SEND;
            w_serout_nxt = w_frame[0];
            w_shift_nxt  = w_frame >> 1;
            w_bitcnt_nxt = '0;
            w_gapcnt_nxt = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serializer
// Brief    : Self-checking bench: frame vectors, loopback receiver scoreboard,
//            FIFO-full, mid-frame reset, idle line and minimum-gap cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serializer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       in_valid;
    logic       in_ready;
    logic       serout;
    logic       busy;
    logic       frame_done;

    logic [7:0] data_g1;
    logic       in_valid_g1;
    logic       in_ready_g1;
    logic       serout_g1;
    logic       busy_g1;
    logic       frame_done_g1;

    always #5 clock = ~clock;

    serializer #(.DEPTH(4), .GAP_BITS(18)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .data       (data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .serout     (serout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    serializer #(.DEPTH(4), .GAP_BITS(1)) u_dut_g1 (
        .clock      (clock),
        .reset      (reset),
        .data       (data_g1),
        .in_valid   (in_valid_g1),
        .in_ready   (in_ready_g1),
        .serout     (serout_g1),
        .busy       (busy_g1),
        .frame_done (frame_done_g1)
    );

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         acc_count = 0;
    logic [7:0] sb[$];
    int         match_cycles[$];
    logic [17:0] win = '0;

    typedef struct {
        logic [7:0]  d;
        logic [17:0] frame;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Receiver model on the default DUT: records accepted bytes, recovers frames.
    always @(negedge clock) begin
        logic       m;
        logic [7:0] e;
        cyc++;
        if (reset) begin
            sb.delete();
            win = '0;
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back(data);
                acc_count++;
            end
            win = {serout, win[17:1]};
            m   = (win[4:0] == 5'b10001) && (win[17:13] == 5'b01110);
            if (m || frame_done) check("frame_done_vs_rx", {63'd0, frame_done}, {63'd0, m});
            if (m) begin
                match_cycles.push_back(cyc);
                if (sb.size() == 0) begin
                    check("rx_spurious_frame", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rx_byte", {56'd0, win[12:5]}, {56'd0, e});
                end
            end
        end
    end

    task automatic wait_drain(input int bound, input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < bound) begin
            tick();
            n++;
        end
        check(name, {63'd0, n < bound}, 64'd1);
    endtask

    // Caller sits just after a rising edge; the byte is accepted at the next one.
    task automatic send_frame(input logic [7:0] d, input logic [17:0] exp, input int idx);
        logic [17:0] got;
        logic [17:0] fd;
        logic        gap_bad;
        data     = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check($sformatf("latency_idle[%0d]", idx), {62'd0, serout, busy}, 64'd0);
        for (int k = 0; k < 18; k++) begin
            tick();
            got[k] = serout;
            fd[k]  = frame_done;
        end
        check($sformatf("frame_bits[%0d]", idx), {46'd0, got}, {46'd0, exp});
        check($sformatf("frame_done_pos[%0d]", idx), {46'd0, fd}, 64'h2_0000);
        gap_bad = 1'b0;
        for (int g = 0; g < 18; g++) begin
            tick();
            gap_bad |= serout | frame_done | ~busy;
        end
        check($sformatf("gap_zeros[%0d]", idx), {63'd0, gap_bad}, 64'd0);
        tick();
        check($sformatf("idle_after_gap[%0d]", idx), {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [7:0]  burst[4];
        logic [36:0] stream;
        logic [36:0] fdg;
        int          lowc;

        vecs[0] = '{8'hA5, 18'b01110_10100101_10001};
        vecs[1] = '{8'h00, 18'b01110_00000000_10001};
        vecs[2] = '{8'hFF, 18'b01110_11111111_10001};
        vecs[3] = '{8'h3C, 18'b01110_00111100_10001};
        vecs[4] = '{8'hC3, 18'b01110_11000011_10001};

        reset       = 1'b1;
        data        = '0;
        in_valid    = 1'b0;
        data_g1     = '0;
        in_valid_g1 = 1'b0;
        repeat (3) tick();
        check("reset_state", {60'd0, serout, in_ready, busy, frame_done}, 64'b0100);
        reset = 1'b0;

        // Idle line
        acc = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            acc |= serout | busy | frame_done;
        end
        check("idle_line", {63'd0, acc}, 64'd0);

        // Single frames from idle
        for (int i = 0; i < 5; i++) send_frame(vecs[i].d, vecs[i].frame, i);

        // Loopback burst
        burst = '{8'h00, 8'hFF, 8'h3C, 8'hC3};
        match_cycles.delete();
        for (int j = 0; j < 4; j++) begin
            data     = burst[j];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        wait_drain(400, "burst_drain");
        check("burst_frames", match_cycles.size(), 64'd4);
        for (int j = 1; j < match_cycles.size(); j++)
            check("burst_period", match_cycles[j] - match_cycles[j-1], 64'd36);

        // FIFO full: valid held 8 cycles
        acc_count = 0;
        data      = 8'h10;
        in_valid  = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            data = data + 8'd1;
        end
        in_valid = 1'b0;
        check("fifo_accepts", acc_count, 64'd5);
        lowc = 0;
        while (!in_ready && lowc < 100) begin
            tick();
            lowc++;
        end
        check("fifo_full_hold", lowc, 64'd30);
        wait_drain(300, "fifo_drain");

        // Reset mid-frame with bytes buffered
        data     = 8'hFF;
        in_valid = 1'b1;
        tick();
        data = 8'h55;
        tick();
        data = 8'h66;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        check("pre_reset_bit9", {63'd0, serout}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_midframe", {61'd0, serout, busy, in_ready}, 64'b001);
        acc = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            acc |= serout | busy | frame_done;
        end
        check("no_tx_after_reset", {63'd0, acc}, 64'd0);

        // Minimum gap on the GAP_BITS=1 instance
        check("g1_ready", {63'd0, in_ready_g1}, 64'd1);
        data_g1     = 8'h5A;
        in_valid_g1 = 1'b1;
        tick();
        data_g1 = 8'h81;
        tick();
        in_valid_g1 = 1'b0;
        for (int t = 0; t < 37; t++) begin
            stream[t] = serout_g1;
            fdg[t]    = frame_done_g1;
            tick();
        end
        check("min_gap_stream", {27'd0, stream},
              {27'd0, 18'b01110_10000001_10001, 1'b0, 18'b01110_01011010_10001});
        check("min_gap_done", {27'd0, fdg}, (64'd1 << 36) | (64'd1 << 17));
        repeat (5) tick();
        check("min_gap_idle", {63'd0, busy_g1}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serializer.md
# serializer

Transmit-side serializer for the lab 4 serial link. It accepts bytes over a valid/ready handshake and buffers them in a small FIFO. Each byte goes out on a single serial line as an 18-bit framed word, one bit per clock, and idle gaps of zeros separate the frames. Its `serout` drives the bit-clocked `deserializer` directly, which recovers each byte and raises a one-cycle `outclock` per frame.

## Interface
- `DEPTH`, default 4: FIFO depth in bytes; power of two, minimum 2.
- `GAP_BITS`, default 18: zero bits sent between consecutive frames; legal 1..255.
- `clock` input 1: bit clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `data` input 8: byte to transmit.
- `in_valid` input 1: `data` is valid this cycle.
- `in_ready` output 1: FIFO can accept; equals not-full.
- `serout` output 1: serial line, registered.
- `busy` output 1: high while the FSM is in SEND or GAP.
- `frame_done` output 1: one-cycle pulse.

## Operation
- **Frame format**, in transmit order (bit 0 first, bit 17 last):
  - bits 0..4: preamble 1,0,0,0,1.
  - bits 5..12: data[0]..data[7], LSB first.
  - bits 13..17: postamble 0,1,1,1,0.
- **Receive-side view**: at the deserializer this equals a window with `window[4:0]=5'b10001`, `window[12:5]=data`, `window[17:13]=5'b01110`.
- **Push**: a byte is pushed on an edge where `in_valid && in_ready`. A push into a full FIFO is impossible, because `in_ready` is low. When the FIFO is full, a pop in the same cycle does not open room for a push.
- **FSM states**:
  - IDLE: `serout`=0. If the FIFO is non-empty, pop the head, load the 18-bit frame shift register, drive bit 0 onto `serout`, set bitcnt=0 and go to SEND.
  - SEND: each edge shifts the next bit onto `serout` and increments bitcnt. After bit 17 has been on `serout` for one cycle, go to GAP with gapcnt=0 and `serout`=0.
  - GAP: `serout`=0 for GAP_BITS cycles. Then, if the FIFO is non-empty, load the next frame directly, as IDLE does, in the same edge. Otherwise go to IDLE.
- **No gap after reset or from IDLE**: the line is already zero, so a frame may start immediately.
- **frame_done**: high exactly during the cycle in which bit 17 is on `serout`.
- **Counter widths**: bitcnt is 5 bits; gapcnt is 8 bits. Neither counter wraps; each is cleared on every state entry.
- **No false match**: with GAP_BITS ≥ 18, no 18-bit window that straddles a frame boundary matches the preamble/postamble mask.

## Timing
- **Reset values**: `serout`=0, `in_ready`=1, `busy`=0, `frame_done`=0. The FIFO is empty and the FSM is in IDLE.
- **Latency**: a byte pushed at edge N into an empty FIFO while the FSM is IDLE is popped at edge N+1. Frame bit k is then on `serout` during the cycle after edge N+1+k.
- **Frame period**: back-to-back frames start every 18+GAP_BITS cycles (36 at the default).
- **Reset mid-frame**: `serout` is 0 from the next cycle and the frame is truncated. The FIFO is flushed, no `frame_done` pulses, and the FSM returns to IDLE.
- **Push and pop in the same edge**: when the FIFO is not full, both occur and the count is unchanged.
- **Empty FIFO**: when the FSM pops a byte from an empty FIFO with a same-cycle push, the byte goes through the FIFO. It is popped on the following edge, so there is no bypass path.

## Structure
- **Package `serializer_pkg`**:
  - FRAME_BITS=18.
  - PREAMBLE=5'b10001 and POSTAMBLE=5'b01110, both in receive-window order.
  - DATA_LSB=5.
  - FSM state enum: IDLE, SEND, GAP.
- **Sub-module `serializer_fifo`**:
  - Synchronous show-ahead FIFO with `DEPTH` parameter and ports push/pop/full/empty/head.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- **Top level**: FSM, frame shift register and counters.

## Test plan
- **Single byte**: push 0xA5 from idle → `serout` = 1,0,0,0,1, 1,0,1,0,0,1,0,1, 0,1,1,1,0 starting the cycle after edge N+1. `frame_done` is high with the final 0, followed by 18 zeros.
- **Loopback burst**: connect `serout` to the deserializer and push 0x00, 0xFF, 0x3C, 0xC3 back-to-back → the receiver outputs the same four bytes in order. `outclock` pulses are exactly 36 cycles apart, with no spurious pulses.
- **FIFO full**: with DEPTH=4, hold `in_valid` high for 8 cycles from idle → 5 bytes accepted (1 in flight + 4 buffered), then `in_ready` stays low until the next pop.
- **Reset mid-frame**: assert `reset` while bit 9 is on `serout` → the next cycle shows `serout`=0, `busy`=0 and `in_ready`=1. Buffered bytes are never transmitted and `frame_done` does not pulse.
- **Idle line**: no pushes for 200 cycles after reset → `serout`=0, `busy`=0 and `frame_done`=0 throughout.
- **Minimum gap**: with GAP_BITS=1, push two bytes → the second frame's preamble starts 19 cycles after the first frame's bit 0.
